// File: rtl/univ_shift_engine.sv
// univ_shift_engine: iterative universal shift/rotate engine.
// A working register and carry flag are shifted up to STEP single-bit steps
// per clock until the requested amount has been consumed.
//
// Handshake: while idle (busy=0, done=0), a cycle with start=1 and load=0 is
// accepted on the rising edge; busy stays high for every SHIFT cycle, and done
// pulses for exactly one cycle once the result is final on data_out/carry.
// load, start, mode and shamt are ignored while busy or done.
module univ_shift_engine #(
    parameter int WIDTH = 16,
    parameter int STEP  = 1,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             cin,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [SHW:0]     shamt,
    output logic [WIDTH-1:0] data_out,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    localparam int RW = SHW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [2:0]       mode_q;
    logic [RW-1:0]    remaining;
    logic [WIDTH-1:0] shift_data;
    logic             shift_carry;
    logic [RW-1:0]    rem_next;

    // One single-bit step of the selected operation; returns {carry, data}.
    function automatic logic [WIDTH:0] step1(input logic [2:0] m,
                                             input logic [WIDTH-1:0] d,
                                             input logic c);
        logic [WIDTH:0] r;
        case (m)
            3'b000, 3'b010: r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
            3'b001:         r = {d[0], 1'b0, d[WIDTH-1:1]};
            3'b011:         r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
            3'b100:         r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
            3'b101:         r = {d[0], d[0], d[WIDTH-1:1]};
            3'b110:         r = {d[WIDTH-1], d[WIDTH-2:0], c};
            default:        r = {d[0], c, d[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    // Apply min(STEP, remaining) single-bit steps and compute the leftover amount.
    always_comb begin
        shift_data  = data_out;
        shift_carry = carry;
        for (int i = 0; i < STEP; i++) begin
            if (RW'(i) < remaining) begin
                {shift_carry, shift_data} = step1(mode_q, shift_data, shift_carry);
            end
        end
        rem_next = (remaining > RW'(STEP)) ? remaining - RW'(STEP) : '0;
    end

    // Control FSM plus working register, carry flag and remaining-amount counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            data_out  <= '0;
            carry     <= 1'b0;
            mode_q    <= 3'b000;
            remaining <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        data_out <= data_in;
                        carry    <= cin;
                    end else if (start) begin
                        mode_q    <= mode;
                        remaining <= shamt;
                        state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    data_out  <= shift_data;
                    carry     <= shift_carry;
                    remaining <= rem_next;
                    if (rem_next == '0) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status flags decode straight from the state register.
    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_univ_shift_engine.sv
// Bench for univ_shift_engine: runs a STEP=1 and a STEP=4 instance side by
// side on the same stimulus and compares both against a reference model.
module tb_univ_shift_engine;

    localparam int W   = 16;
    localparam int SHW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         load, cin, start;
    logic [W-1:0] data_in;
    logic [2:0]   mode;
    logic [SHW:0] shamt;

    logic [W-1:0] dout1, dout4;
    logic         carry1, carry4, busy1, busy4, done1, done4;

    univ_shift_engine #(.WIDTH(W), .STEP(1)) dut1 (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .cin(cin),
        .start(start), .mode(mode), .shamt(shamt),
        .data_out(dout1), .carry(carry1), .busy(busy1), .done(done1)
    );

    univ_shift_engine #(.WIDTH(W), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .cin(cin),
        .start(start), .mode(mode), .shamt(shamt),
        .data_out(dout4), .carry(carry4), .busy(busy4), .done(done4)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_data;
    logic         m_carry;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference model: whole operation at once, from arithmetic on the amount.
    function automatic logic [W:0] model_op(input logic [2:0] m, input int n,
                                            input logic [W-1:0] d, input logic c);
        logic [W-1:0] r;
        logic         rc;
        logic [W:0]   ring;
        int           k;
        if (n == 0) return {c, d};
        r  = '0;
        rc = 1'b0;
        case (m)
            3'd0, 3'd2: begin
                r  = (n >= W) ? '0 : d << n;
                rc = (n <= W) ? d[W-n] : 1'b0;
            end
            3'd1: begin
                r  = (n >= W) ? '0 : d >> n;
                rc = (n <= W) ? d[n-1] : 1'b0;
            end
            3'd3: begin
                r  = $signed(d) >>> n;
                rc = (n <= W) ? d[n-1] : d[W-1];
            end
            3'd4: begin
                k  = n % W;
                r  = (k == 0) ? d : ((d << k) | (d >> (W - k)));
                rc = r[0];
            end
            3'd5: begin
                k  = n % W;
                r  = (k == 0) ? d : ((d >> k) | (d << (W - k)));
                rc = r[W-1];
            end
            3'd6: begin
                ring = {c, d};
                k    = n % (W + 1);
                if (k != 0) ring = (ring << k) | (ring >> (W + 1 - k));
                {rc, r} = ring;
            end
            default: begin
                ring = {d, c};
                k    = n % (W + 1);
                if (k != 0) ring = (ring >> k) | (ring << (W + 1 - k));
                {r, rc} = ring;
            end
        endcase
        return {rc, r};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_load(input logic [W-1:0] d, input logic c);
        @(negedge clk);
        load = 1'b1; data_in = d; cin = c;
        @(negedge clk);
        load = 1'b0;
        m_data  = d;
        m_carry = c;
        check("load_data_s1", dout1, d);
        check("load_data_s4", dout4, d);
    endtask

    // Start one operation and follow both instances to completion.
    task automatic run_op(input logic [2:0] m, input int n, input bit interfere);
        logic [W:0]   e;
        logic [W-1:0] ed;
        int first1, first4, b1, b4, d1, d4, lat1, lat4;
        e = model_op(m, n, m_data, m_carry);
        exp_q.push_back(e[W-1:0]);
        lat1 = ((n == 0) ? 1 : n) + 1;
        lat4 = ((n == 0) ? 1 : (n + 3) / 4) + 1;
        first1 = -1; first4 = -1; b1 = 0; b4 = 0; d1 = 0; d4 = 0;
        @(negedge clk);
        mode = m; shamt = n[SHW:0]; start = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (busy1) b1++;
            if (busy4) b4++;
            if (done1) begin d1++; if (first1 < 0) first1 = cyc; end
            if (done4) begin d4++; if (first4 < 0) first4 = cyc; end
            start = 1'b0;
            load  = 1'b0;
            if (interfere && cyc == 1) begin
                start = 1'b1; load = 1'b1; data_in = 16'hFFFF;
                mode = ~m; shamt = 5'd7;
            end
            if (first1 > 0 && first4 > 0 &&
                cyc >= ((first1 > first4) ? first1 : first4) + 2) break;
        end
        ed = exp_q.pop_front();
        check("latency_s1", first1, lat1);
        check("latency_s4", first4, lat4);
        check("busy_cycles_s1", b1, lat1 - 1);
        check("busy_cycles_s4", b4, lat4 - 1);
        check("done_pulses_s1", d1, 1);
        check("done_pulses_s4", d4, 1);
        check("data_s1", dout1, ed);
        check("data_s4", dout4, ed);
        check("carry_s1", carry1, e[W]);
        check("carry_s4", carry4, e[W]);
        m_data  = e[W-1:0];
        m_carry = e[W];
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [W-1:0] d;
        logic         c;
        logic [2:0]   m;
        int           n;
        logic [W-1:0] exp_d;
        logic         exp_c;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{16'hC693, 1'b0, 3'd4, 3,  16'h349E, 1'b0};
        vecs[1] = '{16'hC693, 1'b0, 3'd5, 2,  16'hF1A4, 1'b1};
        vecs[2] = '{16'hC693, 1'b0, 3'd3, 4,  16'hFC69, 1'b0};
        vecs[3] = '{16'hC693, 1'b0, 3'd1, 4,  16'h0C69, 1'b0};
        vecs[4] = '{16'hC693, 1'b1, 3'd6, 1,  16'h8D27, 1'b1};
        vecs[5] = '{16'hC693, 1'b0, 3'd0, 20, 16'h0000, 1'b0};
        vecs[6] = '{16'hC693, 1'b0, 3'd0, 6,  16'hA4C0, 1'b1};
        vecs[7] = '{16'hC693, 1'b1, 3'd0, 0,  16'hC693, 1'b1};
        vecs[8] = '{16'hC693, 1'b0, 3'd7, 1,  16'h6349, 1'b1};
        vecs[9] = '{16'hC693, 1'b0, 3'd2, 6,  16'hA4C0, 1'b1};

        rst = 1'b1; load = 1'b0; cin = 1'b0; start = 1'b0;
        data_in = '0; mode = 3'd0; shamt = '0;
        m_data = '0; m_carry = 1'b0;

        #1;
        check("reset_data_s1", dout1, 16'h0000);
        check("reset_data_s4", dout4, 16'h0000);
        check("reset_carry", {carry1, carry4}, 2'b00);
        check("reset_busy", {busy1, busy4}, 2'b00);
        check("reset_done", {done1, done4}, 2'b00);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_load(vecs[i].d, vecs[i].c);
            run_op(vecs[i].m, vecs[i].n, 1'b0);
            check("table_data_s1", dout1, vecs[i].exp_d);
            check("table_data_s4", dout4, vecs[i].exp_d);
            check("table_carry_s1", carry1, vecs[i].exp_c);
            check("table_carry_s4", carry4, vecs[i].exp_c);
        end

        // load and start together: load wins, no operation begins
        @(negedge clk);
        load = 1'b1; start = 1'b1; data_in = 16'h5A5A; cin = 1'b1;
        mode = 3'd4; shamt = 5'd3;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        m_data = 16'h5A5A; m_carry = 1'b1;
        check("ldst_data_s1", dout1, 16'h5A5A);
        check("ldst_data_s4", dout4, 16'h5A5A);
        check("ldst_busy", {busy1, busy4}, 2'b00);
        @(negedge clk);
        check("ldst_busy_later", {busy1, busy4, done1, done4}, 4'b0000);

        // start/load while busy are ignored
        do_load(16'hC693, 1'b0);
        run_op(3'd4, 10, 1'b1);

        // randomized operations, sometimes chaining on the previous result
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) != 0)
                do_load(W'($urandom), 1'($urandom_range(0, 1)));
            run_op(3'($urandom_range(0, 7)), int'($urandom_range(0, 31)), 1'b0);
        end

        // asynchronous reset in the middle of a rol 10
        do_load(16'hC693, 1'b1);
        @(negedge clk);
        mode = 3'd4; shamt = 5'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_busy", {busy1, busy4}, 2'b11);
        #2 rst = 1'b1;
        #1;
        check("async_reset_data_s1", dout1, 16'h0000);
        check("async_reset_data_s4", dout4, 16'h0000);
        check("async_reset_flags", {carry1, carry4, busy1, busy4, done1, done4}, 6'b0);
        @(negedge clk);
        rst = 1'b0;
        m_data = '0; m_carry = 1'b0;
        do_load(16'h1234, 1'b0);
        run_op(3'd5, 5, 1'b0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/univ_shift_engine.md
Name: univ_shift_engine

Overview:
Parametrised iterative universal shift/rotate engine. It generalises the 16-bit universal shift register to any WIDTH and a configurable bits-per-cycle STEP. It adds rotate-through-carry modes, a carry flag, and a start/busy/done handshake. It sits in the datapath as a low-area shifter for multi-cycle ALU operations.

Parameters:
WIDTH, 16, data width in bits (>=4)
STEP, 1, maximum bits shifted per clock; power of 2, 1..WIDTH
SHW, $clog2(WIDTH), derived; the shamt port is SHW+1 bits wide

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  capture data_in and cin while idle
data_in  input  WIDTH  parallel load value
cin  input  1  carry flag load value
start  input  1  begin an operation while idle
mode  input  3  operation: 000 shl, 001 shr, 010 shl (alias), 011 sar, 100 rol, 101 ror, 110 rcl, 111 rcr
shamt  input  SHW+1  total shift amount, 0..2^(SHW+1)-1
data_out  output  WIDTH  working register
carry  output  1  carry flag register
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse when an operation completes

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (async, any state, including mid-operation): data_out=0, carry=0, busy=0, done=0, remaining=0, state=IDLE. Any in-flight operation is discarded.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - load=1: data_out<=data_in and carry<=cin. Load has priority over start in the same cycle; start is then ignored.
  - start=1 with load=0: latch mode, set remaining<=shamt, go to SHIFT.
- SHIFT: busy=1. Each cycle, apply k=min(STEP, remaining) single-bit steps of the latched mode, then remaining-=k. When remaining reaches 0 after the update, go to DONE.
- shamt=0: one SHIFT cycle with k=0. data_out and carry are unchanged; DONE follows.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE. The result is stable on data_out from the DONE cycle onward.
- Latency from start accepted to done high: max(1, ceil(shamt/STEP)) + 1 cycles.
- Single-bit step definitions:
  - shl: out=MSB, data<<1, LSB=0.
  - shr: out=LSB, data>>1, MSB=0.
  - sar: out=LSB, data>>1, MSB kept.
  - rol: data<<1 with MSB into LSB; out=old MSB.
  - ror: out=old LSB, which goes into MSB.
  - rcl: {carry,data} rotated left by 1 (WIDTH+1-bit ring).
  - rcr: {data,carry} rotated right by 1.
- carry after an operation = the bit shifted out by the last single-bit step, for all non-through-carry modes. For rcl/rcr it follows the ring.
- Over-range amounts are legal and processed literally, bit by bit: shl/shr with shamt>=WIDTH give 0; sar gives all sign bits; rotates wrap naturally.
- load, start, mode and shamt are ignored while busy or in DONE. mode and shamt are sampled only on the accepting start cycle.

Test Plan:
- WIDTH=16, STEP=1: load 0xC693 with cin=0, then start rol shamt=3 -> busy for 3 cycles, done on the 4th cycle, data_out=0x349E, carry=0.
- Load 0xC693, then start ror 2 -> data_out=0xF1A4, carry=1. Reload 0xC693, then sar 4 -> 0xFC69, carry=0. Reload, then shr 4 -> 0x0C69, carry=0.
- Load 0xC693 with cin=1, then rcl 1 -> data_out=0x8D27, carry=1. Over-range: shl 20 -> data_out=0x0000, carry=0, done after 21 cycles.
- WIDTH=16, STEP=4: load 0xC693, then shl 6 -> 2 SHIFT cycles (k=4, then k=2), data_out=0xA4C0, carry=1. shamt=0 -> data_out unchanged, done 2 cycles after start.
- Simultaneous load=1 and start=1 in IDLE -> data loaded, no busy. start during busy with a new mode and shamt -> ignored, original result produced.
- Assert rst mid-SHIFT on a rol 10 -> outputs 0 immediately (asynchronously). After release, a fresh load and start operate normally.
